// File: rtl/any1_pkg.sv
// Shared ANY-1 types and constants used by the vector memory sequencer.
package any1_pkg;

  typedef logic [31:0] Instruction;

  localparam int unsigned VMSEQ_NEL = 64;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    GEN,
    REQ,
    DONE
  } vmseq_state_t;

endpackage

// File: rtl/any1_vmem_seq_if.sv
// Issue/agen/memory-side signals of the vector memory element sequencer.
interface any1_vmem_seq_if #(
  parameter int unsigned NEL = any1_pkg::VMSEQ_NEL
) ();
  localparam int unsigned IW = $clog2(NEL);

  logic                 start;
  any1_pkg::Instruction ir;
  logic [IW:0]          vl;
  logic [NEL-1:0]       vmask;
  logic                 abort;
  any1_pkg::Instruction ir_o;
  logic [IW-1:0]        step;
  logic                 busy;
  logic                 mreq;
  logic                 mack;
  logic                 done;
  logic [IW:0]          nreq;

  modport master (
    output start, ir, vl, vmask, abort, mack,
    input  ir_o, step, busy, mreq, done, nreq
  );

  modport slave (
    input  start, ir, vl, vmask, abort, mack,
    output ir_o, step, busy, mreq, done, nreq
  );

endinterface

// File: rtl/any1_vmem_seq.sv
// Walks vector element indices 0..VL-1, skipping masked-off elements, and issues one
// memory request per active element once the agen has registered its effective address.
module any1_vmem_seq
  import any1_pkg::*;
#(
  parameter int unsigned NEL = VMSEQ_NEL
) (
  input logic           clk,
  input logic           rst,
  any1_vmem_seq_if.slave bus
);

  localparam int unsigned IW    = $clog2(NEL);
  localparam logic [IW:0] VlMax = (IW + 1)'(NEL);
  localparam logic [IW:0] One   = (IW + 1)'(1);

  vmseq_state_t   state_q, state_d;
  logic [IW:0]    idx_q, idx_d;
  logic [IW-1:0]  step_q, step_d;
  logic [IW:0]    vl_q, vl_d;
  logic [NEL-1:0] vmask_q, vmask_d;
  Instruction     ir_q, ir_d;
  logic [IW:0]    nreq_q, nreq_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    vl_d    = vl_q;
    vmask_d = vmask_q;
    ir_d    = ir_q;
    nreq_d  = nreq_q;
    // abort wins over any start capture or handshake in the same cycle
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            ir_d    = bus.ir;
            vl_d    = (bus.vl > VlMax) ? VlMax : bus.vl;
            vmask_d = bus.vmask;
            idx_d   = '0;
            nreq_d  = '0;
            state_d = (bus.vl == '0) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (idx_q >= vl_q) begin
            state_d = DONE;
          end else if (vmask_q[idx_q[IW-1:0]]) begin
            step_d  = idx_q[IW-1:0];
            state_d = GEN;
          end else begin
            idx_d = idx_q + One;
          end
        end
        // one cycle for the agen to register ea from the now-stable step
        GEN: state_d = REQ;
        REQ: begin
          if (bus.mack) begin
            nreq_d  = nreq_q + One;
            idx_d   = idx_q + One;
            state_d = SCAN;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      vl_q    <= '0;
      vmask_q <= '0;
      ir_q    <= '0;
      nreq_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      vl_q    <= vl_d;
      vmask_q <= vmask_d;
      ir_q    <= ir_d;
      nreq_q  <= nreq_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.mreq = (state_q == REQ);
  assign bus.done = (state_q == DONE);
  assign bus.step = step_q;
  assign bus.ir_o = ir_q;
  assign bus.nreq = nreq_q;

endmodule
